// File: rtl/param_fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
package param_fifo_pkg;

   // Status bundle produced by the pointer logic each cycle.
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module param_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PTR_WIDTH-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [PTR_WIDTH-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   // Storage is deliberately not reset; pointers define which words are valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with thresholds, occupancy, sticky errors,
// synchronous flush and optional first-word-fall-through read.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_WIDTH  = 3,
   parameter int AF_THRESH  = FIFO_DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter bit FWFT       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   // Elaboration-time legality checks on the parameter set.
   if (PTR_WIDTH != clog2(FIFO_DEPTH)) begin : g_bad_ptr
      $error("param_fifo: PTR_WIDTH must equal log2(FIFO_DEPTH)");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_fifo: FIFO_DEPTH must be a power of two >= 2");
   end
   if (!(AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH)) begin : g_bad_thresh
      $error("param_fifo: need AE_THRESH < AF_THRESH <= FIFO_DEPTH");
   end

   localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH:0] AF_CNT  = (PTR_WIDTH+1)'(AF_THRESH);
   localparam logic [PTR_WIDTH:0] AE_CNT  = (PTR_WIDTH+1)'(AE_THRESH);

   logic [PTR_WIDTH:0]    wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_accept, wr_accept, wr_refuse, rd_refuse;
   fifo_status_t          status;

   // Occupancy and flags come straight from the registered pointers; the
   // extra wrap bit distinguishes full from empty when the indices match.
   assign count = wr_ptr - rd_ptr;
   assign status.empty        = (wr_ptr == rd_ptr);
   assign status.full         = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                                (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
   assign status.almost_full  = (count >= AF_CNT);
   assign status.almost_empty = (count <= AE_CNT);

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;

   // flush masks both requests; a read frees the slot a write-while-full needs.
   assign rd_accept = rd_en && !status.empty && !flush;
   assign rd_refuse = rd_en &&  status.empty && !flush;
   assign wr_accept = wr_en && (!status.full || rd_accept) && !flush;
   assign wr_refuse = wr_en &&  status.full && !rd_accept && !flush;

   param_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_accept),
      .waddr (wr_ptr[PTR_WIDTH-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr[PTR_WIDTH-1:0]),
      .rdata (rd_data)
   );

   // Pointer advance; natural rollover of the wrap bit needs no special case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_refuse) overflow  <= 1'b1;
         if (rd_refuse) underflow <= 1'b1;
      end
   end

   if (FWFT) begin : g_fwft
      // Head word is presented combinationally; rd_en only acknowledges it.
      assign data_out = rd_data;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      // Registered read: load the head word on an accepted pop, else hold.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)         dout_q <= '0;
         else if (flush)     dout_q <= '0;
         else if (rd_accept) dout_q <= rd_data;
      end
      assign data_out = dout_q;
   end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench: a standard-mode and an FWFT instance share stimulus and
// are checked against a queue-based model of FIFO behaviour.
module tb_param_fifo;

   localparam int DW = 8, DEPTH = 8, PW = 3, AF = 6, AE = 2;

   logic          clk = 1'b0;
   logic          rst_n, flush, wr_en, rd_en;
   logic [DW-1:0] data_in;
   logic [DW-1:0] do0, do1;
   logic          full0, empty0, af0, ae0, ov0, uf0;
   logic          full1, empty1, af1, ae1, ov1, uf1;
   logic [PW:0]   cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] mq[$];     // FIFO contents, head at index 0
   logic [DW-1:0] exp_q[$];  // expected standard-mode read data
   logic [DW-1:0] m_last;
   bit            m_ov, m_uf;
   bit            pend;

   always #5 clk = ~clk;

   param_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(PW),
                .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(do0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ov0), .underflow(uf0));

   param_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(PW),
                .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fw (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(do1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ov1), .underflow(uf1));

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_last = '0;
      m_ov = 0;
      m_uf = 0;
      pend = 0;
   endtask

   // Drive one cycle of stimulus, then advance the model by FIFO rules.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
      bit ra;
      logic [DW-1:0] v;
      wr_en = w; data_in = d; rd_en = r; flush = f;
      @(posedge clk); #1;
      if (f) begin
         mq.delete();
         m_ov = 0; m_uf = 0; m_last = '0;
      end else begin
         ra = r && (mq.size() > 0);
         if (r && !ra) m_uf = 1;
         if (ra) begin
            v = mq.pop_front();
            m_last = v;
            exp_q.push_back(v);
         end
         if (w) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ov = 1;
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cnt0"}, int'(cnt0), 0);   chk({tag, "_cnt1"}, int'(cnt1), 0);
      chk({tag, "_empty"}, {empty0, empty1}, 2'b11);
      chk({tag, "_ae"}, {ae0, ae1}, 2'b11);
      chk({tag, "_full_af"}, {full0, full1, af0, af1}, 4'b0000);
      chk({tag, "_ovuf"}, {ov0, ov1, uf0, uf1}, 4'b0000);
      chk({tag, "_dout0"}, int'(do0), 0);
   endtask

   // Monitor: compares read data when a pop was presented, and all status each cycle.
   always @(negedge clk) begin
      int sz;
      logic [DW-1:0] e;
      sz = mq.size();
      if (pend) begin
         if (exp_q.size() == 0) chk("rd_data_missing", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rd_data", int'(do0), int'(e));
         end
      end else begin
         chk("dout_hold", int'(do0), int'(m_last));
      end
      chk("count0", int'(cnt0), sz);
      chk("count1", int'(cnt1), sz);
      chk("full",   {full0, full1}, {2{sz == DEPTH}});
      chk("empty",  {empty0, empty1}, {2{sz == 0}});
      chk("afull",  {af0, af1}, {2{sz >= AF}});
      chk("aempty", {ae0, ae1}, {2{sz <= AE}});
      chk("ovf",    {ov0, ov1}, {2{m_ov}});
      chk("udf",    {uf0, uf1}, {2{m_uf}});
      if (sz > 0) chk("fwft_head", int'(do1), int'(mq[0]));
      pend = rst_n && rd_en && !flush && !empty0;
   end

   initial begin
      logic [DW-1:0] d;
      rst_n = 1'b0; flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
      model_reset();
      #2 check_reset_vals("reset_async");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: fill, then overflow
      for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
      step(1, 8'h09, 0, 0);
      // 2: drain, then underflow with data_out held
      for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      // 3: simultaneous read/write at full and at empty
      step(0, '0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, DW'(8'h10 + i), 0, 0);
      step(1, 8'hAA, 1, 0);
      for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
      step(1, 8'h55, 1, 0);
      step(0, '0, 1, 0);
      // 4: wrap-around with interleaved and simultaneous traffic
      step(0, '0, 0, 1);
      d = 8'h20;
      for (int i = 0; i < 20; i++) begin
         step(1, d, 0, 0); d++;
         step(0, '0, 1, 0);
      end
      for (int i = 0; i < 3; i++) begin step(1, d, 0, 0); d++; end
      for (int i = 0; i < 20; i++) begin step(1, d, 1, 0); d++; end
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
      // 5: FWFT head visibility
      step(0, '0, 0, 1);
      step(1, 8'hC3, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      // 6: flush with write at count 5 and overflow set
      for (int i = 0; i < 9; i++) step(1, DW'(8'h40 + i), 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
      step(1, 8'h77, 0, 1);
      step(0, '0, 0, 0);
      // refill, then asynchronous reset between edges
      for (int i = 0; i < 4; i++) step(1, DW'(8'h60 + i), 0, 0);
      step(0, '0, 1, 0);
      wr_en = 0; rd_en = 0; flush = 0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_mid");
      model_reset();
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      step(1, 8'h99, 0, 0);
      chk("first_wr_mem0", int'(u_fw.u_mem.mem[0]), 8'h99);

      // randomized traffic with occasional flush
      for (int i = 0; i < 400; i++)
         step(1'($urandom % 2), DW'($urandom), 1'($urandom % 2), ($urandom % 40) == 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
